ps2_direction_decoder: RTL and testbench



---
 rtl/ps2_direction_decoder_pkg.sv | 31 +++
 rtl/ps2_direction_decoder_if.sv | 19 +
 rtl/ps2_direction_decoder_rx_frame.sv | 117 +++++++++++
 rtl/ps2_direction_decoder.sv | 96 +++++++++
 tb/tb_ps2_direction_decoder.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_direction_decoder_pkg.sv
// Shared constants for the PS/2 direction decoder: scan codes, direction bit
// positions and the state encodings of the frame and decode FSMs.
package ps2_direction_decoder_pkg;

  localparam logic [7:0] ScExt     = 8'hE0;
  localparam logic [7:0] ScBreak   = 8'hF0;
  localparam logic [7:0] ScW       = 8'h1D;
  localparam logic [7:0] ScS       = 8'h1B;
  localparam logic [7:0] ScA       = 8'h1C;
  localparam logic [7:0] ScD       = 8'h23;
  localparam logic [7:0] ScSpace   = 8'h29;
  localparam logic [7:0] ScUp      = 8'h75;
  localparam logic [7:0] ScDown    = 8'h72;
  localparam logic [7:0] ScLeft    = 8'h6B;
  localparam logic [7:0] ScRight   = 8'h74;

  localparam int unsigned DirUp    = 3;
  localparam int unsigned DirDown  = 2;
  localparam int unsigned DirLeft  = 1;
  localparam int unsigned DirRight = 0;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} frame_st_e;
  typedef enum logic [1:0] {StNorm, StExt, StBrk, StExtBrk} dec_st_e;

  function automatic logic [3:0] dir_onehot(input int unsigned idx);
    logic [3:0] one;
    one = 4'b0001;
    return one << idx;
  endfunction

endpackage

// File: rtl/ps2_direction_decoder_if.sv
// PS/2 pin inputs and decoded direction/status outputs of the direction decoder.
interface ps2_direction_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [3:0] dir_out;
  logic       dir_valid;
  logic       start_pulse;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_dat,
    input  dir_out, dir_valid, start_pulse, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output dir_out, dir_valid, start_pulse, frame_err
  );
endinterface

// File: rtl/ps2_direction_decoder_rx_frame.sv
// PS/2 receiver: pin synchronisers, ps2_clk glitch filter, 11-bit frame FSM
// with odd-parity/stop checking and an inter-edge timeout.
module ps2_direction_decoder_rx_frame
  import ps2_direction_decoder_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       byte_done_o,
  output logic [7:0] byte_o,
  output logic       err_o
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FiltW-1:0] FiltMax = FiltW'(FILTER_LEN - 1);
  localparam logic [ToW-1:0]   ToMax   = ToW'(TIMEOUT_CYCLES - 1);

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             filt_q, filt_d, filt_prev_q;
  logic [FiltW-1:0] fcnt_q, fcnt_d;
  logic             strobe, dat_bit;
  frame_st_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;

  // Pins idle high, so synchronisers and filter start high to avoid a false edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q  <= {dat_sync_q[0], ps2_dat_i};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FiltMax) filt_d = clk_sync_q[1];
      else                   fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign strobe  = filt_prev_q & ~filt_q;
  assign dat_bit = dat_sync_q[1];
  assign byte_o  = shift_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    to_cnt_d    = to_cnt_q;
    byte_done_o = 1'b0;
    err_o       = 1'b0;

    if (state_q == StIdle || strobe) to_cnt_d = '0;
    else if (to_cnt_q != ToMax)      to_cnt_d = to_cnt_q + 1'b1;

    if (strobe) begin
      unique case (state_q)
        StIdle: begin
          if (!dat_bit) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            err_o = 1'b1;
          end
        end
        StData: begin
          shift_d   = {dat_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = dat_bit;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (dat_bit && (^{shift_q, par_q})) byte_done_o = 1'b1;
          else                                err_o       = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && to_cnt_q == ToMax) begin
      state_d = StIdle;
      err_o   = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_direction_decoder.sv
// Snake-game input stage: decodes WASD / arrow make-codes into a held one-hot
// direction, pulses start on Space and flags malformed PS/2 frames.
module ps2_direction_decoder
  import ps2_direction_decoder_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                     clk,
  input logic                     reset_n,
  ps2_direction_decoder_if.slave  bus_io
);

  logic       rx_done, rx_err;
  logic [7:0] rx_byte;
  dec_st_e    dec_q, dec_d;
  logic [3:0] dir_q, dir_d;
  logic       dir_valid_q, dir_valid_d;
  logic       start_q, start_d;
  logic       frame_err_q;

  ps2_direction_decoder_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx_frame (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .ps2_clk_i   (bus_io.ps2_clk),
    .ps2_dat_i   (bus_io.ps2_dat),
    .byte_done_o (rx_done),
    .byte_o      (rx_byte),
    .err_o       (rx_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_q       <= StNorm;
      dir_q       <= '0;
      dir_valid_q <= 1'b0;
      start_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      dir_q       <= dir_d;
      dir_valid_q <= dir_valid_d;
      start_q     <= start_d;
      frame_err_q <= rx_err;
    end
  end

  always_comb begin
    dec_d       = dec_q;
    dir_d       = dir_q;
    dir_valid_d = 1'b0;
    start_d     = 1'b0;
    if (rx_done) begin
      unique case (dec_q)
        StNorm: begin
          case (rx_byte)
            ScExt:   dec_d = StExt;
            ScBreak: dec_d = StBrk;
            ScW:     begin dir_d = dir_onehot(DirUp);    dir_valid_d = 1'b1; end
            ScS:     begin dir_d = dir_onehot(DirDown);  dir_valid_d = 1'b1; end
            ScA:     begin dir_d = dir_onehot(DirLeft);  dir_valid_d = 1'b1; end
            ScD:     begin dir_d = dir_onehot(DirRight); dir_valid_d = 1'b1; end
            ScSpace: start_d = 1'b1;
            default: ;
          endcase
        end
        StExt: begin
          dec_d = StNorm;
          case (rx_byte)
            ScExt:   dec_d = StExt;
            ScBreak: dec_d = StExtBrk;
            ScUp:    begin dir_d = dir_onehot(DirUp);    dir_valid_d = 1'b1; end
            ScDown:  begin dir_d = dir_onehot(DirDown);  dir_valid_d = 1'b1; end
            ScLeft:  begin dir_d = dir_onehot(DirLeft);  dir_valid_d = 1'b1; end
            ScRight: begin dir_d = dir_onehot(DirRight); dir_valid_d = 1'b1; end
            default: ;
          endcase
        end
        // Released key's code is swallowed.
        StBrk, StExtBrk: dec_d = StNorm;
        default:         dec_d = StNorm;
      endcase
    end else if (rx_err) begin
      dec_d = StNorm;
    end
  end

  assign bus_io.dir_out     = dir_q;
  assign bus_io.dir_valid   = dir_valid_q;
  assign bus_io.start_pulse = start_q;
  assign bus_io.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Bench for ps2_direction_decoder: table of hand-derived frames, timeout,
// start-bit, reset-mid-frame sequences and random frames against a model.
module tb_ps2_direction_decoder;

  typedef struct {
    logic [7:0] code;
    bit         bp;
    bit         bs;
    bit         gl;
    logic [3:0] dir;
    int         v;
    int         s;
    int         e;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #10 clk = ~clk;

  ps2_direction_decoder_if bus ();

  ps2_direction_decoder #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (50000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_io  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int v_hi = 0, v_rise = 0, s_hi = 0, s_rise = 0, e_hi = 0, e_rise = 0;
  int last_v_cyc = 0, last_e_cyc = 0;
  logic v_prev = 1'b0, s_prev = 1'b0, e_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.dir_valid) begin v_hi <= v_hi + 1; last_v_cyc <= cyc; end
    if (bus.start_pulse) s_hi <= s_hi + 1;
    if (bus.frame_err) begin e_hi <= e_hi + 1; last_e_cyc <= cyc; end
    if (bus.dir_valid && !v_prev) v_rise <= v_rise + 1;
    if (bus.start_pulse && !s_prev) s_rise <= s_rise + 1;
    if (bus.frame_err && !e_prev) e_rise <= e_rise + 1;
    v_prev <= bus.dir_valid;
    s_prev <= bus.start_pulse;
    e_prev <= bus.frame_err;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: pending prefix bytes plus the held direction.
  logic [7:0] pfx[$];
  logic [3:0] m_dir = 4'b0000;

  task automatic model_frame(input logic [7:0] code, input bit good, output logic [3:0] edir,
                             output int ev, output int es, output int ee);
    logic [7:0] norm_keys[4];
    logic [7:0] ext_keys[4];
    bit has_brk, ext;
    norm_keys = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    ext_keys  = '{8'h75, 8'h72, 8'h6B, 8'h74};
    ev = 0; es = 0; ee = 0;
    has_brk = 1'b0;
    foreach (pfx[k]) if (pfx[k] == 8'hF0) has_brk = 1'b1;
    if (!good) begin
      ee = 1;
      pfx.delete();
    end else if (has_brk) begin
      pfx.delete();
    end else if (code == 8'hE0 || code == 8'hF0) begin
      pfx.push_back(code);
    end else begin
      ext = (pfx.size() != 0);
      pfx.delete();
      for (int i = 0; i < 4; i++) begin
        if ((ext ? ext_keys[i] : norm_keys[i]) == code) begin
          m_dir = 4'b1000 >> i;
          ev = 1;
        end
      end
      if (!ext && code == 8'h29) es = 1;
    end
    edir = m_dir;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected within [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drive_bit(input logic d, input int half, input bit gl);
    bus.ps2_dat = d;
    if (gl) begin
      wait_cyc(8); bus.ps2_clk = 1'b0; wait_cyc(3); bus.ps2_clk = 1'b1; wait_cyc(half - 11);
    end else begin
      wait_cyc(half);
    end
    bus.ps2_clk = 1'b0;
    fall_cyc = cyc;
    if (gl) begin
      wait_cyc(8); bus.ps2_clk = 1'b1; wait_cyc(3); bus.ps2_clk = 1'b0; wait_cyc(half - 11);
    end else begin
      wait_cyc(half);
    end
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bp, input bit bs, input bit gl,
                            input int half);
    logic [10:0] bits;
    bits = {~bs, (~^code) ^ bp, code, 1'b0};
    for (int i = 0; i < 11; i++) drive_bit(bits[i], half, gl);
    bus.ps2_dat = 1'b1;
    wait_cyc(20);
  endtask

  task automatic frame_check(input string tag, input logic [7:0] code, input bit bp,
                             input bit bs, input bit gl, input int half,
                             input logic [3:0] edir, input int ev, input int es, input int ee);
    int v0, vh0, s0, sh0, e0, eh0;
    v0 = v_rise; vh0 = v_hi; s0 = s_rise; sh0 = s_hi; e0 = e_rise; eh0 = e_hi;
    send_frame(code, bp, bs, gl, half);
    chk({tag, "_dir"}, int'(bus.dir_out), int'(edir));
    chk({tag, "_valid"}, v_rise - v0, ev);
    chk({tag, "_valid_width"}, v_hi - vh0, ev);
    chk({tag, "_start"}, s_rise - s0, es);
    chk({tag, "_start_width"}, s_hi - sh0, es);
    chk({tag, "_err"}, e_rise - e0, ee);
    chk({tag, "_err_width"}, e_hi - eh0, ee);
    if (ev != 0) chk_range({tag, "_latency"}, last_v_cyc - fall_cyc, 2, 15);
  endtask

  task automatic run_model(input string tag, input logic [7:0] code, input bit bp, input bit bs,
                           input bit gl, input int half);
    logic [3:0] ed;
    int ev, es, ee;
    model_frame(code, !(bp || bs), ed, ev, es, ee);
    frame_check(tag, code, bp, bs, gl, half, ed, ev, es, ee);
  endtask

  function automatic vec_t mk(input logic [7:0] c, input bit bp, input bit bs, input bit gl,
                              input logic [3:0] d, input int v, input int s, input int e);
    vec_t t;
    t.code = c; t.bp = bp; t.bs = bs; t.gl = gl; t.dir = d; t.v = v; t.s = s; t.e = e;
    return t;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [7:0] codes[11];
    logic [3:0] ed;
    int ev, es, ee, e0, eh0, v0;

    tbl.push_back(mk(8'h1D, 0, 0, 0, 4'b1000, 1, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 4'b1000, 0, 0, 0));
    tbl.push_back(mk(8'h6B, 0, 0, 0, 4'b0010, 1, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(8'h6B, 0, 0, 0, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(8'h23, 1, 0, 0, 4'b0010, 0, 0, 1));
    tbl.push_back(mk(8'h1B, 0, 0, 0, 4'b0100, 1, 0, 0));
    tbl.push_back(mk(8'h29, 0, 0, 0, 4'b0100, 0, 1, 0));
    tbl.push_back(mk(8'h1C, 0, 0, 1, 4'b0010, 1, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(8'h23, 0, 1, 0, 4'b0010, 0, 0, 1));
    tbl.push_back(mk(8'h74, 0, 0, 0, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(8'h1D, 0, 0, 0, 4'b1000, 1, 0, 0));
    tbl.push_back(mk(8'h1D, 0, 0, 0, 4'b1000, 1, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 4'b1000, 0, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 4'b1000, 0, 0, 0));
    tbl.push_back(mk(8'h72, 0, 0, 0, 4'b0100, 1, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 4'b0100, 0, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 4'b0100, 0, 0, 0));
    tbl.push_back(mk(8'h23, 0, 0, 0, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(8'h29, 0, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(8'h1C, 0, 0, 0, 4'b0010, 1, 0, 0));
    codes = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74};

    reset_n = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    chk("reset_dir", int'(bus.dir_out), 0);
    chk("reset_valid", int'(bus.dir_valid), 0);
    chk("reset_start", int'(bus.start_pulse), 0);
    chk("reset_err", int'(bus.frame_err), 0);
    reset_n = 1'b1;
    wait_cyc(5);

    for (int i = 0; i < tbl.size(); i++) begin
      model_frame(tbl[i].code, !(tbl[i].bp || tbl[i].bs), ed, ev, es, ee);
      frame_check($sformatf("tbl%0d", i), tbl[i].code, tbl[i].bp, tbl[i].bs, tbl[i].gl, 40,
                  tbl[i].dir, tbl[i].v, tbl[i].s, tbl[i].e);
    end

    // Start bit sampled high: error from idle, direction untouched.
    e0 = e_rise; eh0 = e_hi; v0 = v_rise;
    bus.ps2_dat = 1'b1;
    wait_cyc(40); bus.ps2_clk = 1'b0; wait_cyc(40); bus.ps2_clk = 1'b1; wait_cyc(20);
    model_frame(8'h00, 1'b0, ed, ev, es, ee);
    chk("startbit_err", e_rise - e0, 1);
    chk("startbit_err_width", e_hi - eh0, 1);
    chk("startbit_valid", v_rise - v0, 0);
    chk("startbit_dir", int'(bus.dir_out), 4'b0010);

    // Truncated frame then idle clock: timeout error.
    e0 = e_rise; eh0 = e_hi;
    drive_bit(1'b0, 40, 1'b0);
    drive_bit(1'b1, 40, 1'b0);
    drive_bit(1'b0, 40, 1'b0);
    drive_bit(1'b1, 40, 1'b0);
    bus.ps2_dat = 1'b1;
    for (int i = 0; i < 50200 && e_rise == e0; i++) @(posedge clk);
    wait_cyc(20);
    chk("timeout_err", e_rise - e0, 1);
    chk("timeout_err_width", e_hi - eh0, 1);
    chk_range("timeout_latency", last_e_cyc - fall_cyc, 49990, 50030);
    model_frame(8'h00, 1'b0, ed, ev, es, ee);
    run_model("to_e0", 8'hE0, 0, 0, 0, 40);
    run_model("to_right", 8'h74, 0, 0, 0, 40);
    chk("to_right_onehot", int'(bus.dir_out), 4'b0001);

    for (int i = 0; i < 20; i++) begin
      int r;
      logic [7:0] c;
      bit bp, bs, gl;
      r  = $urandom_range(0, 12);
      c  = (r < 11) ? codes[r] : 8'($urandom);
      bp = ($urandom_range(0, 7) == 0);
      bs = !bp && ($urandom_range(0, 15) == 0);
      gl = ($urandom_range(0, 3) == 0);
      run_model($sformatf("rnd%0d", i), c, bp, bs, gl, 20);
    end

    // Reset mid-frame after an E0 prefix.
    run_model("rst_e0", 8'hE0, 0, 0, 0, 40);
    drive_bit(1'b0, 40, 1'b0);
    drive_bit(1'b1, 40, 1'b0);
    reset_n = 1'b0;
    wait_cyc(3);
    @(negedge clk);
    chk("midrst_dir", int'(bus.dir_out), 0);
    chk("midrst_valid", int'(bus.dir_valid), 0);
    chk("midrst_start", int'(bus.start_pulse), 0);
    chk("midrst_err", int'(bus.frame_err), 0);
    reset_n = 1'b1;
    pfx.delete();
    m_dir = 4'b0000;
    wait_cyc(5);
    run_model("after_rst_75", 8'h75, 0, 0, 0, 40);
    chk("after_rst_dir", int'(bus.dir_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
